bz_music_player: RTL

//  Parametrised multi-song buzzer sequencer; successor to the single-song music player.

---
 rtl/bz_music_player_if.sv | 45 ++++
 rtl/bz_music_player.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bz_music_player_if.sv
// Bus bundle for bz_music_player: game-control handshake, song ROM port,
// buzzer drive and a debug view of the sequencer state.
// Optional macro BZ_VOLUME_EN adds the 3-bit volume input.
//
// Handshake semantics: start is a one-cycle request that is accepted only
// while busy is low and stop is low; stop aborts any active playback on the
// next edge; done is a one-cycle pulse, asserted while busy is still high,
// on the cycle a song ends naturally; rom_data must present the word at
// rom_addr one cycle after rom_addr changes.
interface bz_music_player_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int SONG_BITS  = 2,
    parameter int TUNE_WIDTH = 8,
    parameter int BEAT_WIDTH = 4
) ();
    logic                             start;
    logic                             stop;
    logic [SONG_BITS-1:0]             song_sel;
    logic                             loop_en;
    logic [ADDR_WIDTH-1:0]            rom_addr;
    logic [TUNE_WIDTH+BEAT_WIDTH-1:0] rom_data;
    logic                             busy;
    logic                             done;
    logic                             beep;
    logic [2:0]                       dbg_state;
`ifdef BZ_VOLUME_EN
    logic [2:0]                       volume;
`endif

    modport master (
`ifdef BZ_VOLUME_EN
        output volume,
`endif
        output start, stop, song_sel, loop_en, rom_data,
        input  rom_addr, busy, done, beep, dbg_state
    );

    modport slave (
`ifdef BZ_VOLUME_EN
        input  volume,
`endif
        input  start, stop, song_sel, loop_en, rom_data,
        output rom_addr, busy, done, beep, dbg_state
    );
endinterface

// File: rtl/bz_music_player.sv
// bz_music_player: multi-song buzzer sequencer. Walks note words {tune, beat}
// from a synchronous song ROM and drives a square-wave tone on beep, with
// rests, end markers, loop mode and a silent gap after every note.
// Optional macro BZ_VOLUME_EN enables duty-cycle volume control on beep.
module bz_music_player #(
    parameter int ADDR_WIDTH = 9,
    parameter int SONG_BITS  = 2,
    parameter int TUNE_WIDTH = 8,
    parameter int BEAT_WIDTH = 4,
    parameter int TONE_SCALE = 64,
    parameter int BEAT_TICKS = 3125000,
    parameter int GAP_TICKS  = 250000
) (
    input  logic             clk,
    input  logic             rst,
    bz_music_player_if.slave bus
);
    localparam int LOW_BITS = ADDR_WIDTH - SONG_BITS;
    localparam int TONE_MAX = ((2 ** TUNE_WIDTH) - 1) * TONE_SCALE;
    localparam int BEAT_MAX = ((2 ** BEAT_WIDTH) - 1) * BEAT_TICKS;
    localparam int TCW      = (TONE_MAX > 1) ? $clog2(TONE_MAX + 1) : 1;
    localparam int BCW      = (BEAT_MAX > 1) ? $clog2(BEAT_MAX + 1) : 1;
    localparam int GCW      = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int GAP_M1   = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [TUNE_WIDTH-1:0] tune_q,     tune_d;
    logic [BEAT_WIDTH-1:0] beat_q,     beat_d;
    logic [TCW-1:0]        tone_cnt_q, tone_cnt_d;
    logic                  phase_q,    phase_d;
    logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [GCW-1:0]        gap_cnt_q,  gap_cnt_d;
`ifdef BZ_VOLUME_EN
    logic [2:0]            duty_cnt_q, duty_cnt_d;
`endif

    logic [TUNE_WIDTH-1:0] rd_tune;
    logic [BEAT_WIDTH-1:0] rd_beat;
    logic [BEAT_WIDTH-1:0] rd_beat_eff;
    logic [TCW-1:0]        half_m1;
    logic [BCW-1:0]        note_m1;
    logic [ADDR_WIDTH-1:0] song_base;
    logic                  region_end;
    logic                  end_evt;
    logic                  step_evt;

    assign rd_tune     = bus.rom_data[TUNE_WIDTH+BEAT_WIDTH-1:BEAT_WIDTH];
    assign rd_beat     = bus.rom_data[BEAT_WIDTH-1:0];
    // A zero beat on a sounding note still plays for one beat.
    assign rd_beat_eff = (rd_beat == '0) ? BEAT_WIDTH'(1) : rd_beat;
    assign half_m1     = TCW'(tune_q) * TCW'(TONE_SCALE) - TCW'(1);
    assign note_m1     = BCW'(beat_q) * BCW'(BEAT_TICKS) - BCW'(1);
    // The song index lives in the top address bits, which never change mid-song.
    assign song_base   = {rom_addr_q[ADDR_WIDTH-1:LOW_BITS], {LOW_BITS{1'b0}}};
    assign region_end  = &rom_addr_q[LOW_BITS-1:0];

    // Next-state logic: sequencing, tone/beat/gap counting, end handling, stop override.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tune_d     = tune_q;
        beat_d     = beat_q;
        tone_cnt_d = tone_cnt_q;
        phase_d    = phase_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
`ifdef BZ_VOLUME_EN
        duty_cnt_d = '0;
`endif
        end_evt    = 1'b0;
        step_evt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    rom_addr_d = {bus.song_sel, {LOW_BITS{1'b0}}};
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                tune_d     = rd_tune;
                beat_d     = rd_beat_eff;
                tone_cnt_d = '0;
                phase_d    = 1'b0;
                beat_cnt_d = '0;
                if (bus.rom_data == '0) end_evt = 1'b1;
                else                    state_d = S_PLAY;
            end
            S_PLAY: begin
`ifdef BZ_VOLUME_EN
                duty_cnt_d = duty_cnt_q + 3'd1;
`endif
                beat_cnt_d = beat_cnt_q + BCW'(1);
                // Rests keep the phase at 0 for the whole note.
                if (tune_q != '0) begin
                    if (tone_cnt_q == half_m1) begin
                        tone_cnt_d = '0;
                        phase_d    = !phase_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + TCW'(1);
                    end
                end
                if (beat_cnt_q == note_m1) begin
                    if (GAP_TICKS > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        step_evt = 1'b1;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GCW'(1);
                if (gap_cnt_q == GCW'(GAP_M1)) step_evt = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // Advancing past the last word of the region counts as an end marker.
        if (step_evt) begin
            if (region_end) begin
                end_evt = 1'b1;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                state_d    = S_FETCH;
            end
        end
        if (end_evt) begin
            if (bus.loop_en) begin
                rom_addr_d = song_base;
                state_d    = S_FETCH;
            end else begin
                state_d = S_IDLE;
            end
        end
        if (bus.stop && state_q != S_IDLE) state_d = S_IDLE;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= '0;
            tune_q     <= '0;
            beat_q     <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
`ifdef BZ_VOLUME_EN
            duty_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tune_q     <= tune_d;
            beat_q     <= beat_d;
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef BZ_VOLUME_EN
            duty_cnt_q <= duty_cnt_d;
`endif
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.dbg_state = state_q;
    // done marks the cycle of a natural end; an abort or reset suppresses it.
    assign bus.done      = end_evt && !bus.loop_en && !bus.stop && !rst;
`ifdef BZ_VOLUME_EN
    assign bus.beep      = phase_q && (state_q == S_PLAY) && (duty_cnt_q <= bus.volume);
`else
    assign bus.beep      = phase_q && (state_q == S_PLAY);
`endif
endmodule
